// File: rtl/mau_host_driver_if.sv
// Host-side bundle between the upstream command/byte streams, the driver and the matrix
// algebra unit's byte-wide host port. The driver is the master; the host-side bench is the slave.
interface mau_host_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [1:0] cmd_bram_a;
  logic [1:0] cmd_bram_b;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic [7:0] host_instruction;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy_flag;
  logic       done;
  logic       timeout;

  modport master (
    input  cmd_valid, cmd_op, cmd_bram_a, cmd_bram_b, wr_valid, wr_data, data_out, busy_flag,
    output cmd_ready, wr_ready, rd_valid, rd_data, host_instruction, data_in, done, timeout
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_bram_a, cmd_bram_b, wr_valid, wr_data, data_out, busy_flag,
    input  cmd_ready, wr_ready, rd_valid, rd_data, host_instruction, data_in, done, timeout
  );
endinterface

// File: rtl/mau_host_driver.sv
// Host-side initiator for the matrix algebra unit: issues opcodes, frames matrix loads/stores
// and tracks the busy flag of arithmetic commands through to completion or timeout.
module mau_host_driver #(
  parameter int unsigned matrix_dim   = 8,
  parameter int unsigned read_latency = 2,
  parameter int unsigned busy_timeout = 1024
) (
  input logic               clk,
  input logic               reset,
  mau_host_driver_if.master bus
);
  localparam int unsigned NumBytes = matrix_dim * matrix_dim;
  localparam int unsigned CntW     = $clog2(NumBytes) + 1;
  localparam int unsigned TmrMax   = (busy_timeout > read_latency) ? busy_timeout : read_latency;
  localparam int unsigned TmrW     = $clog2(TmrMax + 1);

  localparam logic [CntW-1:0] CntLast  = CntW'(NumBytes - 1);
  localparam logic [TmrW-1:0] TmoLast  = TmrW'(busy_timeout - 1);
  localparam logic [TmrW-1:0] WaitLast = (read_latency > 1) ? TmrW'(read_latency - 2) : '0;

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpData  = 3'b001;
  localparam logic [2:0] OpLoad  = 3'b010;
  localparam logic [2:0] OpStore = 3'b011;
  localparam logic [2:0] OpShift = 3'b111;

  typedef enum logic [2:0] {
    StIdle, StIssue, StLoad, StStoreWait, StStoreCap, StBusyRise, StBusyFall, StFin
  } state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [CntW-1:0] count_q;
  logic [TmrW-1:0] timer_q;
  logic            cmd_ready_q;
  logic            wr_ready_q;
  logic            rd_valid_q;
  logic [7:0]      rd_data_q;
  logic [7:0]      instr_q;
  logic            done_q;
  logic            timeout_q;
  logic            load_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      instr_q     <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      instr_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            cmd_ready_q <= 1'b0;
            if (bus.cmd_op == OpNop || bus.cmd_op == OpData) begin
              done_q  <= 1'b1;
              state_q <= StFin;
            end else begin
              instr_q <= {bus.cmd_op, bus.cmd_bram_a,
                          (bus.cmd_op == OpShift) ? 2'b00 : bus.cmd_bram_b, 1'b0};
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          timer_q <= '0;
          case (op_q)
            OpLoad: begin
              wr_ready_q <= 1'b1;
              state_q    <= StLoad;
            end
            OpStore: state_q <= (read_latency > 1) ? StStoreWait : StStoreCap;
            default: state_q <= StBusyRise;
          endcase
        end
        StLoad: begin
          if (bus.wr_valid) begin
            if (count_q == CntLast) begin
              count_q    <= '0;
              wr_ready_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= StFin;
            end else begin
              count_q <= count_q + CntW'(1);
            end
          end
        end
        StStoreWait: begin
          if (timer_q == WaitLast) begin
            timer_q <= '0;
            state_q <= StStoreCap;
          end else begin
            timer_q <= timer_q + TmrW'(1);
          end
        end
        StStoreCap: begin
          // The capture is presented upstream one cycle later; the last one lands in FIN.
          rd_valid_q <= 1'b1;
          rd_data_q  <= bus.data_out;
          if (count_q == CntLast) begin
            count_q <= '0;
            done_q  <= 1'b1;
            state_q <= StFin;
          end else begin
            count_q <= count_q + CntW'(1);
          end
        end
        StBusyRise, StBusyFall: begin
          if (bus.busy_flag == (state_q == StBusyRise)) begin
            timer_q <= '0;
            if (state_q == StBusyRise) begin
              state_q <= StBusyFall;
            end else begin
              done_q  <= 1'b1;
              state_q <= StFin;
            end
          end else if (timer_q >= TmoLast) begin
            // Abort shares the FIN cycle so cmd_ready returns one cycle after the pulse.
            timer_q   <= '0;
            timeout_q <= 1'b1;
            state_q   <= StFin;
          end else begin
            timer_q <= timer_q + TmrW'(1);
          end
        end
        StFin: begin
          count_q     <= '0;
          timer_q     <= '0;
          cmd_ready_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // DATA bytes go out in the same cycle the upstream byte is consumed.
  assign load_fire = (state_q == StLoad) && bus.wr_valid && wr_ready_q;

  assign bus.host_instruction = load_fire ? 8'h20 : instr_q;
  assign bus.data_in          = load_fire ? bus.wr_data : 8'h00;
  assign bus.cmd_ready        = cmd_ready_q;
  assign bus.wr_ready         = wr_ready_q;
  assign bus.rd_valid         = rd_valid_q;
  assign bus.rd_data          = rd_data_q;
  assign bus.done             = done_q;
  assign bus.timeout          = timeout_q;
endmodule

// File: tb/tb_mau_host_driver.sv
// Directed bench for mau_host_driver: a default instance plus a short-timeout instance,
// with small behavioural models of the matrix unit's store data and busy flag.
module tb_mau_host_driver;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  int st_ph = 0;
  int bp = 0;
  int busy_delay = 3;
  int busy_len = 20;

  mau_host_driver_if bus ();
  mau_host_driver_if bus2 ();

  mau_host_driver u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  mau_host_driver #(
    .busy_timeout (16)
  ) u_dut_to (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Store model: 0xA0+i on data_out from 2 cycles after the 0x78 opcode cycle.
  always @(negedge clk) begin
    if (st_ph != 0) begin
      bus.data_out = (st_ph >= 2 && st_ph <= 65) ? 8'(8'hA0 + st_ph - 2) : 8'h00;
      st_ph = (st_ph == 66) ? 0 : st_ph + 1;
    end else if (bus.host_instruction == 8'h78) begin
      st_ph = 1;
    end
  end

  // Busy model: arithmetic opcode seen -> busy from busy_delay cycles later for busy_len cycles.
  always @(negedge clk) begin
    if (bp != 0) begin
      bus.busy_flag = (bp >= busy_delay) && (bp < busy_delay + busy_len);
      bp = (bp >= busy_delay + busy_len) ? 0 : bp + 1;
    end else if (bus.host_instruction[7]) begin
      bp = 1;
    end
  end

  task automatic send_cmd(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
    bit ok = 1'b0;
    bus.cmd_op = op;
    bus.cmd_bram_a = a;
    bus.cmd_bram_b = b;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = bus.cmd_ready;
      @(posedge clk);
      #1;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_cmd: cmd_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    n_cmp++; if (bus.wr_ready !== 1'b0 || bus.rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_ready_valid: got wr_ready=%b rd_valid=%b want 0/0",
               bus.wr_ready, bus.rd_valid); end
    n_cmp++; if (bus.host_instruction !== 8'h00 || bus.data_in !== 8'h00) begin n_bad++;
      $display("FAIL reset_bus: got instr=%h data_in=%h want 00/00",
               bus.host_instruction, bus.data_in); end
    n_cmp++; if (bus.done !== 1'b0 || bus.timeout !== 1'b0 || bus.rd_data !== 8'h00) begin
      n_bad++; $display("FAIL reset_pulses: got done=%b timeout=%b rd_data=%h want 0/0/00",
                        bus.done, bus.timeout, bus.rd_data); end
    n_cmp++; if (bus2.cmd_ready !== 1'b1) begin n_bad++;
      $display("FAIL reset_cmd_ready_to: got %b want 1", bus2.cmd_ready); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_nop();
    logic [2:0] ops [2];
    ops[0] = 3'b000;
    ops[1] = 3'b001;
    for (int i = 0; i < 2; i++) begin
      send_cmd(ops[i], 2'd1, 2'd1);
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b1 || bus.host_instruction !== 8'h00) begin n_bad++;
        $display("FAIL nop_done op=%0d: got done=%b instr=%h want 1/00",
                 i, bus.done, bus.host_instruction); end
      @(posedge clk);
      #1;
      @(negedge clk);
      n_cmp++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_bad++;
        $display("FAIL nop_after op=%0d: got done=%b cmd_ready=%b want 0/1",
                 i, bus.done, bus.cmd_ready); end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_load();
    int n = 0;
    int done_k = -1;
    int last_k = -1;
    logic [7:0] first_b = 8'h00;
    send_cmd(3'b010, 2'd1, 2'd0);
    bus.wr_valid = 1'b1;
    for (int k = 0; k < 40 && n < 10; k++) begin
      bus.wr_data = 8'(k);
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) n++;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.host_instruction !== 8'h00 || bus.data_in !== 8'h00) begin n_bad++;
      $display("FAIL midrst_bus: got instr=%h data_in=%h want 00/00",
               bus.host_instruction, bus.data_in); end
    n_cmp++; if (bus.wr_ready !== 1'b0 || bus.cmd_ready !== 1'b1) begin n_bad++;
      $display("FAIL midrst_ready: got wr_ready=%b cmd_ready=%b want 0/1",
               bus.wr_ready, bus.cmd_ready); end
    n_cmp++; if (bus.done !== 1'b0 || bus.rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL midrst_pulses: got done=%b rd_valid=%b want 0/0", bus.done, bus.rd_valid); end
    bus.wr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_cmd(3'b010, 2'd1, 2'd0);
    n = 0;
    bus.wr_valid = 1'b1;
    for (int k = 0; k < 200 && done_k < 0; k++) begin
      bus.wr_data = 8'(8'h80 + n);
      @(negedge clk);
      if (k == 0) begin
        n_cmp++; if (bus.host_instruction !== 8'h48) begin n_bad++;
          $display("FAIL midrst_reload_op: got %h want 48", bus.host_instruction); end
      end
      if (bus.wr_valid && bus.wr_ready) begin
        if (n == 0) first_b = bus.data_in;
        n++;
        last_k = k;
      end
      if (bus.done) done_k = k;
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    n_cmp++; if (n != 64) begin n_bad++;
      $display("FAIL midrst_reload_count: got %0d bytes want 64", n); end
    n_cmp++; if (done_k != last_k + 1) begin n_bad++;
      $display("FAIL midrst_reload_done: got done at %0d want %0d", done_k, last_k + 1); end
    n_cmp++; if (first_b !== 8'h80) begin n_bad++;
      $display("FAIL midrst_reload_first: got %h want 80", first_b); end
  endtask

  task automatic test_load();
    int idx = 0;
    int n_iss = 0;
    int bad_d = 0;
    int bad_gap = 0;
    int last_k = -1;
    int done_k = -1;
    send_cmd(3'b010, 2'd2, 2'd0);
    for (int k = 0; k < 300 && done_k < 0; k++) begin
      bus.wr_valid = (k % 2 == 0) && (idx < 64);
      bus.wr_data = 8'(idx);
      @(negedge clk);
      if (bus.host_instruction == 8'h50) n_iss++;
      if (bus.wr_valid && bus.wr_ready) begin
        if (bus.host_instruction !== 8'h20 || bus.data_in !== 8'(idx)) bad_d++;
        idx++;
        last_k = k;
      end else if (k > 0 && (bus.host_instruction !== 8'h00 || bus.data_in !== 8'h00)) begin
        bad_gap++;
      end
      if (bus.done) done_k = k;
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    n_cmp++; if (n_iss != 1) begin n_bad++;
      $display("FAIL load_opcode: got %0d cycles of 0x50 want 1", n_iss); end
    n_cmp++; if (idx != 64) begin n_bad++;
      $display("FAIL load_count: got %0d DATA cycles want 64", idx); end
    n_cmp++; if (bad_d != 0) begin n_bad++;
      $display("FAIL load_data: got %0d bad DATA cycles want 0", bad_d); end
    n_cmp++; if (bad_gap != 0) begin n_bad++;
      $display("FAIL load_gap: got %0d non-NOP gap cycles want 0", bad_gap); end
    n_cmp++; if (done_k != last_k + 1) begin n_bad++;
      $display("FAIL load_done: got done at %0d want %0d", done_k, last_k + 1); end
  endtask

  task automatic test_store();
    int n = 0;
    int bad = 0;
    int first_k = -1;
    int last_k = -1;
    int done_k = -1;
    int n_to = 0;
    int stray = 0;
    send_cmd(3'b011, 2'd3, 2'd0);
    for (int k = 0; k < 200 && done_k < 0; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++; if (bus.host_instruction !== 8'h78) begin n_bad++;
          $display("FAIL store_opcode: got %h want 78", bus.host_instruction); end
      end
      if (bus.rd_valid) begin
        if (bus.rd_data !== 8'(8'hA0 + n)) bad++;
        if (first_k < 0) first_k = k;
        last_k = k;
        n++;
      end
      if (bus.done) done_k = k;
      if (bus.timeout) n_to++;
      @(posedge clk);
      #1;
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.rd_valid) stray++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (n != 64) begin n_bad++;
      $display("FAIL store_count: got %0d rd_valid pulses want 64", n); end
    n_cmp++; if (bad != 0) begin n_bad++;
      $display("FAIL store_data: got %0d wrong bytes want 0", bad); end
    n_cmp++; if (first_k != 3) begin n_bad++;
      $display("FAIL store_latency: got first pulse at %0d want 3", first_k); end
    n_cmp++; if (last_k - first_k != 63) begin n_bad++;
      $display("FAIL store_contig: got span %0d want 63", last_k - first_k); end
    n_cmp++; if (done_k < last_k || done_k > last_k + 1) begin n_bad++;
      $display("FAIL store_done: got done at %0d want %0d..%0d", done_k, last_k, last_k + 1); end
    n_cmp++; if (n_to != 0 || stray != 0) begin n_bad++;
      $display("FAIL store_tail: got timeout=%0d stray=%0d want 0/0", n_to, stray); end
  endtask

  task automatic test_arith();
    int done_k = -1;
    int n_to = 0;
    int n_wr = 0;
    busy_delay = 3;
    busy_len = 20;
    send_cmd(3'b100, 2'd0, 2'd1);
    bus.wr_valid = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++; if (bus.host_instruction !== 8'h82) begin n_bad++;
          $display("FAIL add_opcode: got %h want 82", bus.host_instruction); end
      end
      if (k == 24) begin
        n_cmp++; if (bus.cmd_ready !== 1'b0) begin n_bad++;
          $display("FAIL add_ready_fin: got %b want 0", bus.cmd_ready); end
      end
      if (k == 25) begin
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_bad++;
          $display("FAIL add_ready_idle: got %b want 1", bus.cmd_ready); end
      end
      if (bus.done && done_k < 0) done_k = k;
      if (bus.timeout) n_to++;
      if (bus.wr_ready) n_wr++;
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    n_cmp++; if (done_k != 24) begin n_bad++;
      $display("FAIL add_done: got done at %0d want 24", done_k); end
    n_cmp++; if (n_to != 0) begin n_bad++;
      $display("FAIL add_timeout: got %0d pulses want 0", n_to); end
    n_cmp++; if (n_wr != 0) begin n_bad++;
      $display("FAIL add_wr_ready: got %0d cycles high want 0", n_wr); end
  endtask

  task automatic test_timeout();
    int to_k = -1;
    int n_to = 0;
    int n_done = 0;
    bit ok;
    bus2.cmd_op = 3'b110;
    bus2.cmd_bram_a = 2'd1;
    bus2.cmd_bram_b = 2'd2;
    bus2.cmd_valid = 1'b1;
    @(negedge clk);
    ok = bus2.cmd_ready;
    @(posedge clk);
    #1;
    bus2.cmd_valid = 1'b0;
    n_cmp++; if (ok !== 1'b1) begin n_bad++;
      $display("FAIL mul_accept: got cmd_ready=%b want 1", ok); end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_cmp++; if (bus2.host_instruction !== 8'hCC) begin n_bad++;
          $display("FAIL mul_opcode: got %h want cc", bus2.host_instruction); end
      end
      if (k == 17) begin
        n_cmp++; if (bus2.cmd_ready !== 1'b0) begin n_bad++;
          $display("FAIL mul_ready_pulse: got %b want 0", bus2.cmd_ready); end
      end
      if (k == 18) begin
        n_cmp++; if (bus2.cmd_ready !== 1'b1) begin n_bad++;
          $display("FAIL mul_ready_after: got %b want 1", bus2.cmd_ready); end
      end
      if (bus2.timeout) begin
        n_to++;
        if (to_k < 0) to_k = k;
      end
      if (bus2.done) n_done++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (to_k != 17 || n_to != 1) begin n_bad++;
      $display("FAIL mul_timeout: got first at %0d count %0d want 17/1", to_k, n_to); end
    n_cmp++; if (n_done != 0) begin n_bad++;
      $display("FAIL mul_done: got %0d done pulses want 0", n_done); end
  endtask

  task automatic test_back_to_back();
    int first_iss = -1;
    int sec_iss = -1;
    int first_done = -1;
    int n_done = 0;
    int n_hi = 0;
    int bad_op = 0;
    int n_rd = 0;
    int bad_rd = 0;
    bus.cmd_op = 3'b011;
    bus.cmd_bram_a = 2'd3;
    bus.cmd_bram_b = 2'd0;
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 400 && n_done < 2; k++) begin
      @(negedge clk);
      if (bus.host_instruction !== 8'h00) begin
        n_hi++;
        if (bus.host_instruction !== 8'h78) bad_op++;
        if (first_iss < 0) first_iss = k;
        else if (sec_iss < 0) sec_iss = k;
      end
      if (bus.rd_valid) begin
        if (bus.rd_data !== 8'(8'hA0 + (n_rd % 64))) bad_rd++;
        n_rd++;
      end
      if (bus.done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      @(posedge clk);
      #1;
      if (first_iss >= 0 && k == first_iss + 20) bus.cmd_op = 3'b100;
      if (first_iss >= 0 && k == first_iss + 40) bus.cmd_op = 3'b011;
      if (sec_iss >= 0) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.host_instruction !== 8'h00) n_hi++;
      @(posedge clk);
      #1;
    end
    n_cmp++; if (n_hi != 2 || bad_op != 0) begin n_bad++;
      $display("FAIL b2b_opcodes: got %0d issues (%0d not 0x78) want 2/0", n_hi, bad_op); end
    n_cmp++; if (n_done != 2) begin n_bad++;
      $display("FAIL b2b_done: got %0d done pulses want 2", n_done); end
    n_cmp++; if (sec_iss - first_done < 2) begin n_bad++;
      $display("FAIL b2b_spacing: got %0d cycles done->issue want >=2", sec_iss - first_done); end
    n_cmp++; if (n_rd != 128 || bad_rd != 0) begin n_bad++;
      $display("FAIL b2b_rd: got %0d pulses %0d wrong want 128/0", n_rd, bad_rd); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'b000;
    bus.cmd_bram_a = 2'd0;
    bus.cmd_bram_b = 2'd0;
    bus.wr_valid = 1'b0;
    bus.wr_data = 8'h00;
    bus.data_out = 8'h00;
    bus.busy_flag = 1'b0;
    bus2.cmd_valid = 1'b0;
    bus2.cmd_op = 3'b000;
    bus2.cmd_bram_a = 2'd0;
    bus2.cmd_bram_b = 2'd0;
    bus2.wr_valid = 1'b0;
    bus2.wr_data = 8'h00;
    bus2.data_out = 8'h00;
    bus2.busy_flag = 1'b0;
    test_reset();
    test_nop();
    test_reset_mid_load();
    test_load();
    test_store();
    test_arith();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mau_host_driver.md
Name: mau_host_driver

Overview:
- Host-side initiator for the matrix algebra unit's byte-wide host port. It turns upstream commands and byte streams into host_instruction/data_in sequences, and collects matrix bytes from data_out.
- Sits between the host link (UART/bus bridge) and the matrix algebra unit.
- Owns the protocol sequencing: opcode issue, 64-byte load/store framing, and busy-flag completion tracking.

Parameters:
- matrix_dim, 8, matrix side length; bytes per matrix NB = matrix_dim*matrix_dim (64).
- read_latency, 2, cycles from STORE opcode cycle to the first valid data_out byte (range 1..15).
- busy_timeout, 1024, maximum cycles spent waiting in either busy phase before aborting.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  driver idle, accepts command.
- cmd_op  in  3  opcode (encoding below).
- cmd_bram_a  in  2  BRAM A select (LOAD/STORE target, arithmetic source and destination).
- cmd_bram_b  in  2  BRAM B select (arithmetic second operand).
- wr_valid  in  1  upstream load byte valid.
- wr_ready  out  1  driver consumes wr_data this cycle.
- wr_data  in  8  load byte.
- rd_valid  out  1  store byte valid, single-cycle, no backpressure.
- rd_data  out  8  store byte.
- host_instruction  out  8  to matrix algebra unit.
- data_in  out  8  to matrix algebra unit.
- data_out  in  8  from matrix algebra unit.
- busy_flag  in  1  from matrix algebra unit.
- done  out  1  one-cycle pulse at command completion.
- timeout  out  1  one-cycle pulse when a command is aborted on timeout.

Behaviour:
- Instruction byte is {op[2:0], a[1:0], b[1:0], 1'b0}.
- Opcodes: 000 NOP, 001 DATA, 010 LOAD, 011 STORE, 100 ADD, 101 SUB, 110 MUL, 111 SHIFT.
- Arithmetic result is written back to BRAM a. SHIFT ignores b.
- Opcodes NOP and DATA on cmd_op are accepted and complete immediately: done pulses the next cycle, and nothing is issued on the bus.
- Reset (any cycle, including mid-command): state IDLE; all outputs 0 except cmd_ready=1; byte counter 0; timers 0.
- host_instruction is 8'h00 in every cycle not explicitly listed below.
- data_in is 0 except in DATA cycles.
- States: IDLE, ISSUE, LOAD, STORE_WAIT, STORE_CAP, BUSY_RISE, BUSY_FALL, FIN.
  - IDLE: cmd_ready=1. On cmd_valid, register op/a/b, drop cmd_ready, go to ISSUE.
  - ISSUE: host_instruction = opcode byte for exactly one cycle. Next state: LOAD→LOAD; STORE→STORE_WAIT; arithmetic→BUSY_RISE.
  - LOAD:
    - wr_ready=1 while count<NB.
    - Each cycle with wr_valid&wr_ready: host_instruction=8'h20 (DATA), data_in=wr_data, count++.
    - Cycles without wr_valid drive NOP (stall permitted, unbounded).
    - Byte NB-1 accepted → FIN.
  - STORE_WAIT: wait read_latency-1 cycles → STORE_CAP.
  - STORE_CAP:
    - Each cycle: rd_data=data_out (registered, one-cycle delay), rd_valid=1, count++.
    - Exactly NB consecutive pulses, then → FIN.
  - BUSY_RISE: wait for busy_flag=1 → BUSY_FALL. Timer ≥ busy_timeout → abort.
  - BUSY_FALL: wait for busy_flag=0 → FIN. Timer restarts at entry; same abort rule.
  - Abort: timeout=1 for one cycle, no done pulse, → IDLE.
  - FIN: done=1 for one cycle, count=0, → IDLE. cmd_ready returns the cycle after FIN.
- Commands back-to-back: minimum spacing is one IDLE cycle between FIN and the next ISSUE.
- busy_flag already high in ISSUE cycle: BUSY_RISE passes on first sampled 1.
- Byte counter width is clog2(NB)+1. No wrap: terminal compare at NB-1.
- wr_valid outside LOAD is ignored; wr_ready stays 0.
- cmd_valid while busy is ignored and not queued.

Test Plan:
- Reset mid-LOAD after 10 bytes → all outputs immediately 0, cmd_ready=1; a fresh LOAD a=1 is then accepted and the counter restarts at 0.
- LOAD a=2 with 64 bytes 0x00..0x3F, wr_valid toggled 1/0 → host_instruction 0x50 once, then exactly 64 DATA (0x20) cycles carrying 0x00..0x3F in order, NOP on gap cycles, done one cycle after byte 63.
- STORE a=3, model returns 0xA0+i starting read_latency=2 cycles after the 0x78 opcode → 64 rd_valid pulses carrying 0xA0..0xDF, then done.
- ADD a=0 b=1 (opcode 0x82): model raises busy 3 cycles later, holds it 20 cycles → done one cycle after busy falls; timeout stays 0.
- MUL with busy never asserted, busy_timeout=16 → timeout pulses after 16 cycles in BUSY_RISE, no done, cmd_ready=1 next cycle.
- cmd_valid held high across two STORE commands → second opcode issued no earlier than 2 cycles after the first done; cmd_op change during STORE_CAP has no effect.
